maxnet_driver: RTL and testbench
================================

Name: maxnet_driver

Overview:
- Initiator-side front end for the Maxnet winner-take-all core.
- Accepts a stream of WIDTH-bit samples over a valid/ready handshake and packs four consecutive samples into X1..X4.
- Issues a single-cycle start to Maxnet, waits for done, captures the result, and presents it downstream on a valid/ready handshake.
- Sits between the sample source and the Maxnet instance, replacing hand-driven start/X stimulus.

Parameters:
- WIDTH, 5, bit width of each sample, of X1..X4 and of the result.
- TIMEOUT, 255, maximum WAIT cycles before abort. Used only when MAXNET_DRV_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  sample from the source.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  driver accepts a sample this cycle.
- mn_start  out  1  start pulse to Maxnet.
- mn_x1, mn_x2, mn_x3, mn_x4  out  WIDTH each  registered operands to Maxnet.
- mn_done  in  1  Maxnet completion.
- mn_result  in  WIDTH  Maxnet winner value.
- res_data  out  WIDTH  captured result.
- res_valid  out  1  res_data is valid.
- res_ready  in  1  downstream accepts the result.
- res_err  out  1  result aborted by timeout; constant 0 without the macro.
- busy  out  1  high in every state except COLLECT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=COLLECT, sample count=0.
  - mn_x1..mn_x4=0, mn_start=0.
  - res_data=0, res_valid=0, res_err=0, busy=0.
  - in_ready=1 once rst deasserts.
- States: COLLECT, START, WAIT, OUT.
- COLLECT:
  - in_ready=1.
  - A transfer occurs when in_valid&in_ready at a rising edge.
  - Samples fill mn_x1, mn_x2, mn_x3, mn_x4 in arrival order; a 2-bit count increments per transfer.
  - On the 4th transfer: count wraps to 0 and state goes to START.
  - Idle cycles (in_valid=0) hold the partial frame indefinitely.
- START:
  - Exactly one cycle, with mn_start=1 and in_ready=0; next state is WAIT.
  - mn_start rises the cycle after the 4th sample is accepted.
- WAIT:
  - mn_x1..mn_x4 held stable; mn_start=0; in_ready=0.
  - On the first edge with mn_done=1: res_data<=mn_result, res_valid<=1, state goes to OUT.
  - mn_done is ignored in COLLECT, START and OUT, including a done asserted during the START cycle.
- OUT:
  - res_valid=1 and res_data held until res_valid&res_ready at an edge.
  - On that edge: res_valid<=0 and state goes to COLLECT; in_ready=1 on the following cycle.
  - No sample is accepted while in OUT, so there is no overlap of frames.
- Operands persist after a frame completes. mn_x* keep their values until overwritten by the next frame's samples.
- Latency:
  - 4th sample accept edge to mn_start high: 1 cycle.
  - Edge sampling mn_done high to res_valid high: visible in the next cycle.
  - Minimum frame period: 4 (collect) + 1 (START) + Maxnet time + 1 (OUT, with res_ready tied high).
- Width rule: res_data is a plain copy of mn_result; there is no arithmetic in this block.
- Reset mid-operation: any state returns to COLLECT immediately and the partial frame is discarded. Maxnet must be reset by the same rst.

Optional Feature:
- Macro: MAXNET_DRV_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider watchdog clears on entry to WAIT and counts each WAIT cycle.
  - If it reaches TIMEOUT without mn_done: go to OUT with res_data=0, res_err=1, res_valid=1.
  - res_err clears together with res_valid on the handshake.
  - mn_done arriving on the same edge the count reaches TIMEOUT wins: normal capture, res_err=0.
- Not defined: no watchdog logic; WAIT waits forever; res_err tied 0.

Test Plan:
- Basic frame: after reset, stream 2,7,1,6 with in_valid continuous; Maxnet model returns done with result 7 after 10 cycles.
  -> mn_x1..4 = 2,7,1,6; mn_start high exactly 1 cycle, one cycle after 4th accept; res_data=7, res_valid=1 until res_ready.
- Source gaps: in_valid low for 3 cycles between samples 2 and 3, same data.
  -> identical mn_x values; mn_start only after 4th accept; in_ready=0 from START until the OUT handshake.
- Back-pressure: hold res_ready=0 for 20 cycles after done.
  -> res_valid and res_data=7 stable; in_ready=0 and in_valid pulses ignored; after res_ready=1, in_ready=1 the next cycle.
- Spurious done: assert mn_done during COLLECT and during the START cycle.
  -> no capture and no state change; capture only on done in WAIT.
- Reset mid-WAIT: pull rst low in WAIT.
  -> all outputs zero asynchronously; the next frame 1,1,1,9 yields res_data=9 from a fresh count.
- Timeout (macro defined, TIMEOUT=16): never assert mn_done.
  -> after 16 WAIT cycles, res_valid=1, res_err=1, res_data=0; a second run with done on cycle 16 gives res_err=0 and the captured result.

Source files
------------

// File: rtl/maxnet_driver.sv
// Initiator front end for Maxnet: packs four streamed samples into X1..X4, pulses start,
// waits for done and hands the winner downstream. Optional watchdog: MAXNET_DRV_TIMEOUT_EN.
module maxnet_driver #(
    parameter int WIDTH   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mn_start,
    output logic [WIDTH-1:0] mn_x1,
    output logic [WIDTH-1:0] mn_x2,
    output logic [WIDTH-1:0] mn_x3,
    output logic [WIDTH-1:0] mn_x4,
    input  logic             mn_done,
    input  logic [WIDTH-1:0] mn_result,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_err,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and data stable until that edge, ready may change freely.
    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;

`ifdef MAXNET_DRV_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            res_err_q, res_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;
        x4_d        = x4_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
`ifdef MAXNET_DRV_TIMEOUT_EN
        wd_d        = wd_q;
        res_err_d   = res_err_q;
`endif
        case (state_q)
            S_COLLECT: begin
                if (in_valid) begin
                    case (cnt_q)
                        2'd0:    x1_d = in_data;
                        2'd1:    x2_d = in_data;
                        2'd2:    x3_d = in_data;
                        default: x4_d = in_data;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef MAXNET_DRV_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                // A done on the same edge as the watchdog expiry takes priority.
                if (mn_done) begin
                    res_data_d  = mn_result;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
`ifdef MAXNET_DRV_TIMEOUT_EN
                    res_err_d   = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    res_data_d  = '0;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    wd_d        = wd_q + 1'b1;
`endif
                end
            end
            default: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_COLLECT;
`ifdef MAXNET_DRV_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_COLLECT;
            cnt_q       <= 2'd0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            x4_q        <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            x4_q        <= x4_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef MAXNET_DRV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q      <= '0;
            res_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            res_err_q <= res_err_d;
        end
    end
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // Ready is held low while reset is asserted so the source sees no acceptance window.
    assign in_ready  = rst && (state_q == S_COLLECT);
    assign mn_start  = (state_q == S_START);
    assign busy      = (state_q != S_COLLECT);
    assign mn_x1     = x1_q;
    assign mn_x2     = x2_q;
    assign mn_x3     = x3_q;
    assign mn_x4     = x4_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_maxnet_driver.sv
// Directed bench for maxnet_driver: table of frames plus hand-written reset and timeout sequences.
module tb_maxnet_driver;

    localparam int W = 5;
`ifdef MAXNET_DRV_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mn_start;
    logic [W-1:0] mn_x1, mn_x2, mn_x3, mn_x4;
    logic         mn_done = 1'b0;
    logic [W-1:0] mn_result = '0;
    logic [W-1:0] res_data;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         res_err;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    maxnet_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mn_start(mn_start),
        .mn_x1(mn_x1), .mn_x2(mn_x2), .mn_x3(mn_x3), .mn_x4(mn_x4),
        .mn_done(mn_done), .mn_result(mn_result),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_err(res_err), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s0, s1, s2, s3;
        int           gap;
        int           dly;
        int           bp;
        bit           spur;
        logic [W-1:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] max4(input logic [W-1:0] a, b, c, d);
        logic [W-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // driver: offer one sample and wait (bounded) for its acceptance edge
    task automatic send_sample(input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        check("sample_accepted", ok, 1);
    endtask

    task automatic scoreboard_pop();
        if (exp_q.size() == 0) begin
            check("sb_unexpected_result", res_valid, 0);
        end else begin
            check("sb_res_data", res_data, exp_q.pop_front());
        end
    endtask

    task automatic run_frame(input vec_t v);
        exp_q.push_back(v.exp_res);
        if (v.spur) begin
            mn_done   = 1'b1;
            mn_result = 5'd21;
        end
        send_sample(v.s0);
        send_sample(v.s1);
        for (int i = 0; i < v.gap; i++) begin
            check("gap_no_start", mn_start, 0);
            tick();
        end
        send_sample(v.s2);
        check("no_early_start", mn_start, 0);
        send_sample(v.s3);
        check("start_high", mn_start, 1);
        check("start_in_ready", in_ready, 0);
        check("start_busy", busy, 1);
        check("x1", mn_x1, v.s0);
        check("x2", mn_x2, v.s1);
        check("x3", mn_x3, v.s2);
        check("x4", mn_x4, v.s3);
        check("start_no_valid", res_valid, 0);
        tick();
        mn_done = 1'b0;
        check("start_one_cycle", mn_start, 0);
        check("spurious_ignored", res_valid, 0);
        for (int i = 0; i < v.dly; i++) begin
            tick();
            check("wait_in_ready", in_ready, 0);
        end
        mn_done   = 1'b1;
        mn_result = max4(v.s0, v.s1, v.s2, v.s3);
        tick();
        mn_done = 1'b0;
        check("res_valid_set", res_valid, 1);
        check("res_err_clear", res_err, 0);
        check("out_in_ready", in_ready, 0);
        scoreboard_pop();
        for (int i = 0; i < v.bp; i++) begin
            in_valid = i[0];
            in_data  = 5'h1F;
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, v.exp_res);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hs_valid_clear", res_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_busy", busy, 0);
        check("persist_x1", mn_x1, v.s0);
        check("persist_x4", mn_x4, v.s3);
    endtask

    initial begin
        vecs[0] = '{5'd2,  5'd7,  5'd1,  5'd6,  0, 10, 0,  1'b0, 5'd7};
        vecs[1] = '{5'd2,  5'd7,  5'd1,  5'd6,  3, 4,  0,  1'b0, 5'd7};
        vecs[2] = '{5'd2,  5'd7,  5'd1,  5'd6,  0, 2,  20, 1'b0, 5'd7};
        vecs[3] = '{5'd31, 5'd0,  5'd30, 5'd31, 1, 1,  0,  1'b1, 5'd31};
        vecs[4] = '{5'd0,  5'd0,  5'd0,  5'd0,  0, 0,  0,  1'b0, 5'd0};
        vecs[5] = '{5'd5,  5'd12, 5'd12, 5'd3,  2, 3,  3,  1'b1, 5'd12};

        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_start", mn_start, 0);
        check("rst_x1", mn_x1, 0);
        check("rst_x4", mn_x4, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        foreach (vecs[i]) run_frame(vecs[i]);

        // reset with a partial frame pending: asynchronous clear of operands and result
        send_sample(5'd3);
        send_sample(5'd4);
        #2 rst = 1'b0;
        #1;
        check("arst_collect_x1", mn_x1, 0);
        check("arst_collect_res_data", res_data, 0);
        check("arst_collect_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // reset while waiting for done
        send_sample(5'd3);
        send_sample(5'd4);
        send_sample(5'd5);
        send_sample(5'd6);
        tick();
        tick();
        check("pre_arst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_wait_busy", busy, 0);
        check("arst_wait_x1", mn_x1, 0);
        check("arst_wait_x3", mn_x3, 0);
        check("arst_wait_start", mn_start, 0);
        check("arst_wait_res_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_frame('{5'd1, 5'd1, 5'd1, 5'd9, 0, 3, 0, 1'b0, 5'd9});

`ifdef MAXNET_DRV_TIMEOUT_EN
        // watchdog expiry: no done at all
        send_sample(5'd4);
        send_sample(5'd2);
        send_sample(5'd6);
        send_sample(5'd1);
        tick();
        repeat (TO - 1) tick();
        check("to_not_yet", res_valid, 0);
        tick();
        check("to_valid", res_valid, 1);
        check("to_err", res_err, 1);
        check("to_data", res_data, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("to_hs_valid", res_valid, 0);
        check("to_hs_err", res_err, 0);

        // done on the expiry edge wins
        send_sample(5'd5);
        send_sample(5'd3);
        send_sample(5'd8);
        send_sample(5'd2);
        tick();
        repeat (TO - 1) tick();
        mn_done   = 1'b1;
        mn_result = 5'd8;
        tick();
        mn_done = 1'b0;
        check("race_valid", res_valid, 1);
        check("race_err", res_err, 0);
        check("race_data", res_data, 8);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("race_hs_valid", res_valid, 0);
`endif

        // final report
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
